// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered BCD word.
// Optional anode dead time at the start of each digit slot: DISPLAY_SCAN_BLANK_EN.
module display_scan_ctrl #(
    parameter int DIGITS       = 6,
    parameter int TICK_DIV     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            seg_out
);

    // state   | meaning
    // ST_DARK | display off, counters held at 0; next enabled edge shows digit 0
    // ST_SCAN | prescaler/idx running, one digit selected per slot

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
`ifdef DISPLAY_SCAN_BLANK_EN
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
`endif

    if (DIGITS < 2 || DIGITS > 8 || TICK_DIV < 2 || TICK_DIV > 65535
        || BLANK_CYCLES >= TICK_DIV) begin : g_bad_params
        $error("display_scan_ctrl: illegal parameter combination");
    end

    typedef enum logic {ST_DARK, ST_SCAN} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         prescaler, prescaler_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [4*DIGITS-1:0]   shadow, shadow_nxt;
    logic [4*DIGITS-1:0]   active, active_nxt;
    logic                  pending, pending_nxt;
    logic                  commit;
    logic [DIGITS-1:0]     sel_nxt;
    logic [6:0]            seg_nxt;
    logic [3:0]            cur_bcd;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    always_comb begin
        state_nxt     = state;
        prescaler_nxt = '0;
        idx_nxt       = '0;
        commit        = 1'b0;
        shadow_nxt    = load ? digits_in : shadow;
        pending_nxt   = pending | load;
        active_nxt    = active;
        sel_nxt       = '1;
        seg_nxt       = '0;
        cur_bcd       = '0;

        case (state)
            ST_DARK: begin
                if (enable) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_nxt = ST_DARK;
                end else if (prescaler == PRE_LAST) begin
                    if (idx == IDX_LAST) begin
                        commit = pending;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    prescaler_nxt = prescaler + PW'(1);
                    idx_nxt       = idx;
                end
            end
            default: state_nxt = ST_DARK;
        endcase

        // Commit takes the old shadow; a coincident load stays pending for the next frame.
        if (commit) begin
            active_nxt  = shadow;
            pending_nxt = load;
        end

        if (enable) begin
            cur_bcd = active_nxt[{idx_nxt, 2'b00} +: 4];
            seg_nxt = bcd_to_seg(cur_bcd);
            sel_nxt = ~(DIGITS'(1) << idx_nxt);
`ifdef DISPLAY_SCAN_BLANK_EN
            if (prescaler_nxt < BLANK_LIM) sel_nxt = '1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_DARK;
            prescaler <= '0;
            idx       <= '0;
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            load_ack  <= 1'b0;
            digit_sel <= '1;
            seg_out   <= '0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            idx       <= idx_nxt;
            shadow    <= shadow_nxt;
            active    <= active_nxt;
            pending   <= pending_nxt;
            load_ack  <= commit;
            digit_sel <= sel_nxt;
            seg_out   <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (DIGITS=6, TICK_DIV=4, BLANK_CYCLES=1).
// Define DISPLAY_SCAN_BLANK_EN for both bench and RTL to check the dead-time build.
module tb_display_scan_ctrl;

    localparam int DIGITS       = 6;
    localparam int TICK_DIV     = 4;
    localparam int BLANK_CYCLES = 1;
`ifdef DISPLAY_SCAN_BLANK_EN
    localparam int BLANK = BLANK_CYCLES;
`else
    localparam int BLANK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [23:0] digits_in;
    logic        load_ack;
    logic [5:0]  digit_sel;
    logic [6:0]  seg_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [6:0] seg_tab [16];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits_in(digits_in),
        .load(load), .load_ack(load_ack), .digit_sel(digit_sel), .seg_out(seg_out)
    );

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    function automatic logic [5:0] exp_sel(input int d, input int c);
        if (c < BLANK) return 6'h3F;
        return ~(6'd1 << d);
    endfunction

    function automatic logic [6:0] exp_seg(input logic [23:0] v, input int d);
        logic [23:0] t;
        t = v >> (4 * d);
        return seg_tab[t[3:0]];
    endfunction

    // Leaves cyc = -1 so the first enabled edge is E0.
    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0;
        step();
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; load = 1'b1; digits_in = 24'h888888;
        step();
        step();
        checks++; if (digit_sel !== 6'h3F) begin errors++; $display("FAIL reset_sel: got %b expected %b", digit_sel, 6'h3F); end
        checks++; if (seg_out !== 7'd0) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg_out, 7'd0); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", load_ack); end
    endtask

    task automatic test_scan();
        int lit;
        lit = 0;
        do_reset();
        enable = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            for (int c = 0; c < TICK_DIV; c++) begin
                step();
                if (digit_sel !== 6'h3F) lit++;
                checks++; if (digit_sel !== exp_sel(d, c)) begin errors++; $display("FAIL scan_sel d%0d c%0d: got %b expected %b", d, c, digit_sel, exp_sel(d, c)); end
                checks++; if (seg_out !== 7'b1111110) begin errors++; $display("FAIL scan_seg d%0d c%0d: got %b expected %b", d, c, seg_out, 7'b1111110); end
                checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL scan_ack d%0d c%0d: got %b expected 0", d, c, load_ack); end
            end
        end
        checks++; if (lit !== DIGITS * (TICK_DIV - BLANK)) begin errors++; $display("FAIL scan_lit_cycles: got %0d expected %0d", lit, DIGITS * (TICK_DIV - BLANK)); end
    endtask

    task automatic test_load();
        bit ack_seen;
        ack_seen = 1'b0;
        do_reset();
        enable = 1'b1; load = 1'b1; digits_in = 24'h123456;
        step();
        load = 1'b0; digits_in = '0;
        checks++; if (seg_out !== 7'b1111110) begin errors++; $display("FAIL load_old_data: got %b expected %b", seg_out, 7'b1111110); end
        while (cyc < 23) begin
            step();
            if (load_ack) ack_seen = 1'b1;
        end
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL load_early_ack: got %b expected 0", ack_seen); end
        step();
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL load_ack_wrap: got %b expected 1", load_ack); end
        checks++; if (digit_sel !== exp_sel(0, 0)) begin errors++; $display("FAIL load_sel_wrap: got %b expected %b", digit_sel, exp_sel(0, 0)); end
        checks++; if (seg_out !== 7'b1011111) begin errors++; $display("FAIL load_digit0: got %b expected %b", seg_out, 7'b1011111); end
        step();
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL load_ack_width: got %b expected 0", load_ack); end
        for (int d = 1; d < DIGITS; d++) begin
            step_to(24 + 4 * d);
            checks++; if (digit_sel !== exp_sel(d, 0)) begin errors++; $display("FAIL load_sel d%0d: got %b expected %b", d, digit_sel, exp_sel(d, 0)); end
            checks++; if (seg_out !== exp_seg(24'h123456, d)) begin errors++; $display("FAIL load_seg d%0d: got %b expected %b", d, seg_out, exp_seg(24'h123456, d)); end
        end
        checks++; if (seg_out !== 7'b0110000) begin errors++; $display("FAIL load_digit5: got %b expected %b", seg_out, 7'b0110000); end
    endtask

    task automatic test_coincident();
        do_reset();
        enable = 1'b1;
        step_to(23);
        load = 1'b1; digits_in = 24'h999999;
        step();
        load = 1'b0;
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL coinc_no_ack: got %b expected 0", load_ack); end
        checks++; if (seg_out !== 7'b1111110) begin errors++; $display("FAIL coinc_old_seg: got %b expected %b", seg_out, 7'b1111110); end
        step_to(48);
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL coinc_ack_next: got %b expected 1", load_ack); end
        checks++; if (seg_out !== 7'b1111011) begin errors++; $display("FAIL coinc_seg9: got %b expected %b", seg_out, 7'b1111011); end
        step_to(50);
        load = 1'b1; digits_in = 24'h111111;
        step();
        load = 1'b0;
        step_to(71);
        load = 1'b1; digits_in = 24'h777777;
        step();
        load = 1'b0;
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL coinc_pend_ack: got %b expected 1", load_ack); end
        checks++; if (seg_out !== 7'b0110000) begin errors++; $display("FAIL coinc_pend_seg1: got %b expected %b", seg_out, 7'b0110000); end
        step_to(96);
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL coinc_late_ack: got %b expected 1", load_ack); end
        checks++; if (seg_out !== 7'b1110000) begin errors++; $display("FAIL coinc_seg7: got %b expected %b", seg_out, 7'b1110000); end
        step();
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL coinc_ack_drop: got %b expected 0", load_ack); end
    endtask

    task automatic test_back_to_back();
        bit ack_seen;
        ack_seen = 1'b0;
        do_reset();
        enable = 1'b1;
        step_to(2);
        load = 1'b1; digits_in = 24'h111111;
        step();
        load = 1'b0;
        step_to(10);
        load = 1'b1; digits_in = 24'h222222;
        step();
        load = 1'b0;
        step_to(24);
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack: got %b expected 1", load_ack); end
        checks++; if (seg_out !== 7'b1101101) begin errors++; $display("FAIL b2b_seg_wrap: got %b expected %b", seg_out, 7'b1101101); end
        while (cyc < 48) begin
            step();
            if (load_ack) ack_seen = 1'b1;
            checks++; if (seg_out !== 7'b1101101) begin errors++; $display("FAIL b2b_seg cyc%0d: got %b expected %b", cyc, seg_out, 7'b1101101); end
        end
        checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL b2b_single_ack: got %b expected 0", ack_seen); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1; load = 1'b1; digits_in = 24'h0A0000;
        step();
        load = 1'b0;
        step_to(40);
        checks++; if (digit_sel !== exp_sel(4, 0)) begin errors++; $display("FAIL codeA_sel: got %b expected %b", digit_sel, exp_sel(4, 0)); end
        checks++; if (seg_out !== 7'd0) begin errors++; $display("FAIL codeA_seg: got %b expected %b", seg_out, 7'd0); end
        step_to(41);
        enable = 1'b0;
        step();
        checks++; if (digit_sel !== 6'h3F) begin errors++; $display("FAIL dark_sel: got %b expected %b", digit_sel, 6'h3F); end
        checks++; if (seg_out !== 7'd0) begin errors++; $display("FAIL dark_seg: got %b expected %b", seg_out, 7'd0); end
        step_to(43);
        load = 1'b1; digits_in = 24'h000003;
        step();
        load = 1'b0;
        step_to(45);
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL dark_no_ack: got %b expected 0", load_ack); end
        checks++; if (digit_sel !== 6'h3F) begin errors++; $display("FAIL dark_sel_held: got %b expected %b", digit_sel, 6'h3F); end
        enable = 1'b1;
        step();
        checks++; if (digit_sel !== exp_sel(0, 0)) begin errors++; $display("FAIL restart_sel: got %b expected %b", digit_sel, exp_sel(0, 0)); end
        checks++; if (seg_out !== 7'b1111110) begin errors++; $display("FAIL restart_seg: got %b expected %b", seg_out, 7'b1111110); end
        step_to(49);
        checks++; if (digit_sel !== exp_sel(0, 3)) begin errors++; $display("FAIL restart_hold: got %b expected %b", digit_sel, exp_sel(0, 3)); end
        step();
        checks++; if (digit_sel !== exp_sel(1, 0)) begin errors++; $display("FAIL restart_adv: got %b expected %b", digit_sel, exp_sel(1, 0)); end
        step_to(70);
        checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL restart_commit_ack: got %b expected 1", load_ack); end
        checks++; if (seg_out !== 7'b1111001) begin errors++; $display("FAIL restart_seg3: got %b expected %b", seg_out, 7'b1111001); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1;
        step_to(3);
        load = 1'b1; digits_in = 24'h888888;
        step();
        load = 1'b0;
        step_to(10);
        rst_n = 1'b0;
        step();
        checks++; if (digit_sel !== 6'h3F) begin errors++; $display("FAIL midrst_sel: got %b expected %b", digit_sel, 6'h3F); end
        checks++; if (seg_out !== 7'd0) begin errors++; $display("FAIL midrst_seg: got %b expected %b", seg_out, 7'd0); end
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b expected 0", load_ack); end
        rst_n = 1'b1;
        step();
        checks++; if (digit_sel !== exp_sel(0, 0)) begin errors++; $display("FAIL midrst_restart: got %b expected %b", digit_sel, exp_sel(0, 0)); end
        step_to(36);
        checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL midrst_discard_ack: got %b expected 0", load_ack); end
        checks++; if (seg_out !== 7'b1111110) begin errors++; $display("FAIL midrst_discard_seg: got %b expected %b", seg_out, 7'b1111110); end
    endtask

    initial begin
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1111011;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0000000;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_load();
        test_coincident();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
